irq_scheduler: RTL



---
 rtl/irq_scheduler.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/irq_scheduler.sv
// Interrupt scheduler: per-source one-deep pending slots, mask gating, one event presented to the CPU at a time.
// Define IRQ_SCHED_RR_EN for round-robin selection; otherwise the lowest eligible index wins.
module irq_scheduler #(
  parameter int NSRC = 4,
  parameter int IDW  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NSRC-1:0]      src_irq,
  input  logic [32*NSRC-1:0]   src_data,
  input  logic                 mask_we,
  input  logic [NSRC-1:0]      mask_in,
  input  logic                 ack,
  output logic                 irq_out,
  output logic [IDW-1:0]       irq_id,
  output logic [31:0]          irq_data,
  output logic [NSRC-1:0]      ovf
);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [NSRC-1:0] r_pend;
  logic [NSRC-1:0] r_mask;
  logic [NSRC-1:0] r_ovf;
  logic [31:0]     r_slot [NSRC];
  logic [IDW-1:0]  r_irq_id;
  logic [31:0]     r_irq_data;
  logic [NSRC-1:0] w_elig;
  logic [NSRC-1:0] w_ack_clr;
  logic [IDW-1:0]  w_win;
  logic [31:0]     w_win_data;
  logic            w_found;
  logic            w_load;
`ifdef IRQ_SCHED_RR_EN
  logic [IDW-1:0]  r_last_grant;
`endif

  assign w_elig   = r_pend & ~r_mask;
  assign irq_out  = (r_state == ST_PRESENT);
  assign irq_id   = r_irq_id;
  assign irq_data = r_irq_data;
  assign ovf      = r_ovf;

  // Slot released by an acknowledge of the currently presented source.
  always_comb begin
    w_ack_clr = '0;
    for (int i = 0; i < NSRC; i++) begin
      if ((r_state == ST_PRESENT) && ack && (r_irq_id == IDW'(i))) begin
        w_ack_clr[i] = 1'b1;
      end else begin
        w_ack_clr[i] = 1'b0;
      end
    end
  end

`ifdef IRQ_SCHED_RR_EN
  // Round-robin winner: scan indices above the last grant first, then wrap to the bottom.
  always_comb begin
    w_found    = 1'b0;
    w_win      = '0;
    w_win_data = 32'h0000_0000;
    for (int i = 0; i < NSRC; i++) begin
      if (!w_found && w_elig[i] && (IDW'(i) > r_last_grant)) begin
        w_found    = 1'b1;
        w_win      = IDW'(i);
        w_win_data = r_slot[i];
      end else begin
        w_found = w_found;
      end
    end
    for (int i = 0; i < NSRC; i++) begin
      if (!w_found && w_elig[i] && (IDW'(i) <= r_last_grant)) begin
        w_found    = 1'b1;
        w_win      = IDW'(i);
        w_win_data = r_slot[i];
      end else begin
        w_found = w_found;
      end
    end
  end
`else
  // Fixed-priority winner: lowest eligible index.
  always_comb begin
    w_found    = 1'b0;
    w_win      = '0;
    w_win_data = 32'h0000_0000;
    for (int i = 0; i < NSRC; i++) begin
      if (!w_found && w_elig[i]) begin
        w_found    = 1'b1;
        w_win      = IDW'(i);
        w_win_data = r_slot[i];
      end else begin
        w_found = w_found;
      end
    end
  end
`endif

  // Next-state logic; a grant is taken only from IDLE so IDLE always lasts at least one cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_PRESENT;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_PRESENT: begin
        if (ack) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_PRESENT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Presented id/data are captured once at grant time and held until the next grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq_id   <= '0;
      r_irq_data <= 32'h0000_0000;
    end else if (w_load) begin
      r_irq_id   <= w_win;
      r_irq_data <= w_win_data;
    end else begin
      r_irq_id   <= r_irq_id;
      r_irq_data <= r_irq_data;
    end
  end

  // Mask register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mask <= '0;
    end else if (mask_we) begin
      r_mask <= mask_in;
    end else begin
      r_mask <= r_mask;
    end
  end

  // Pending slots: an ack frees the slot in the same cycle, so a simultaneous new event refills it cleanly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= '0;
      r_ovf  <= '0;
      for (int i = 0; i < NSRC; i++) begin
        r_slot[i] <= 32'h0000_0000;
      end
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        if (src_irq[i] && (!r_pend[i] || w_ack_clr[i])) begin
          r_pend[i] <= 1'b1;
          r_slot[i] <= src_data[32*i +: 32];
          r_ovf[i]  <= 1'b0;
        end else if (src_irq[i]) begin
          r_ovf[i]  <= 1'b1;
        end else if (w_ack_clr[i]) begin
          r_pend[i] <= 1'b0;
          r_ovf[i]  <= 1'b0;
        end else begin
          r_pend[i] <= r_pend[i];
        end
      end
    end
  end

`ifdef IRQ_SCHED_RR_EN
  // Last-grant pointer for round-robin search.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= IDW'(NSRC - 1);
    end else if (w_load) begin
      r_last_grant <= w_win;
    end else begin
      r_last_grant <= r_last_grant;
    end
  end
`endif

endmodule
